// File: rtl/reply_serializer_pkg.sv
// Shared definitions for the reply serializer: FSM state codes, default
// sizing and the reply identifiers used by each command handler.
package reply_serializer_pkg;

  localparam int DEFAULT_MAX_BYTES = 8;
  localparam int DEFAULT_LEN_W     = 4;

  // FSM state codes, kept as plain constants so older tools can share them.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  // Reply identifiers, one per command handler.
  localparam logic [7:0] REPLY_ID_STROBE_CTL = 8'h00;
  localparam logic [7:0] REPLY_ID_SEQOP      = 8'h01;
  localparam logic [7:0] REPLY_ID_PULSESEQ0  = 8'h02;
  localparam logic [7:0] REPLY_ID_PULSESEQ1  = 8'h03;
  localparam logic [7:0] REPLY_ID_PULSESEQ2  = 8'h04;
  localparam logic [7:0] REPLY_ID_PULSESEQ3  = 8'h05;
  localparam logic [7:0] REPLY_ID_SAMPLE_CNT = 8'h06;

  // True in every state that presents a byte on the reply bus.
  function automatic logic state_has_byte(input logic [2:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/reply_serializer_byte_sel.sv
// Output datapath of the reply serializer: picks the byte presented on the
// reply bus from the captured request and the running checksum.
module reply_serializer_byte_sel
  import reply_serializer_pkg::*;
#(
  parameter int MAX_BYTES = DEFAULT_MAX_BYTES,
  parameter int LEN_W     = DEFAULT_LEN_W,
  parameter int IDX_W     = 3
) (
  input  logic [2:0]             state,
  input  logic [7:0]             id_q,
  input  logic [LEN_W-1:0]       len_q,
  input  logic [8*MAX_BYTES-1:0] data_q,
  input  logic [IDX_W-1:0]       idx,
  input  logic [7:0]             csum,
  output logic                   reply_rdy,
  output logic [7:0]             reply,
  output logic                   reply_end
);

  logic [7:0] data_byte;

  // Payload byte k lives at bits [8k+7:8k]; payload goes out LSB first.
  assign data_byte = data_q[{idx, 3'b000} +: 8];

  // Byte mux: every output is a pure function of held registers, so the
  // presented byte cannot change while the host stalls.
  always_comb begin
    reply     = 8'h00;
    reply_end = 1'b0;
    reply_rdy = state_has_byte(state);
    case (state)
      ST_ID:   reply = id_q;
      ST_LEN:  reply = 8'(len_q);
      ST_DATA: reply = data_byte;
      ST_CSUM: begin
        reply     = csum;
        reply_end = 1'b1;
      end
      default: reply = 8'h00;
    endcase
  end

endmodule

// File: rtl/reply_serializer.sv
// FPGA->host reply transmitter. Accepts one request word, then sends
// ID, LEN, LEN payload bytes (LSB first) and an XOR checksum byte.
//
// Handshakes: a request transfers on any rising edge with
// req_valid & req_ready; a reply byte transfers on any rising edge with
// reply_rdy & reply_ack. Neither side may retract or alter an offered
// word before it transfers, and reply_ack without reply_rdy is ignored.
module reply_serializer
  import reply_serializer_pkg::*;
#(
  parameter int MAX_BYTES = DEFAULT_MAX_BYTES,
  parameter int LEN_W     = DEFAULT_LEN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_id,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [8*MAX_BYTES-1:0] req_data,
  output logic                   reply_rdy,
  output logic [7:0]             reply,
  input  logic                   reply_ack,
  output logic                   reply_end,
  output logic                   len_err,
  output logic [2:0]             fsm_state
);

  localparam int               IDX_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [7:0]             id_q;
  logic [LEN_W-1:0]       len_q;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [IDX_W-1:0]       idx;
  logic [7:0]             csum;
  logic                   accept;
  logic                   advance;
  logic                   last_data;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign advance   = reply_rdy & reply_ack;
  assign last_data = (LEN_W'(idx) == (len_q - LEN_W'(1)));
  assign fsm_state = state;

  // Next-state logic: one transition per accepted request or acked byte.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_ID;
      ST_ID:   if (advance) state_nxt = ST_LEN;
      ST_LEN:  if (advance) state_nxt = (len_q != '0) ? ST_DATA : ST_CSUM;
      ST_DATA: if (advance && last_data) state_nxt = ST_CSUM;
      ST_CSUM: if (advance) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Holding registers for the accepted request; length clamped on capture
  // so the LEN byte and the payload count always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q   <= 8'h00;
      len_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      id_q   <= req_id;
      len_q  <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
      data_q <= req_data;
    end
  end

  // Length error: a single-cycle flag raised the cycle after an oversize
  // request is accepted; the frame still goes out with the clamped length.
  always_ff @(posedge clk) begin
    if (reset) len_err <= 1'b0;
    else       len_err <= accept && (req_len > MAX_LEN);
  end

  // Running checksum: restarted per frame, folds in every acked byte that
  // precedes the checksum byte itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= 8'h00;
    end else if (accept) begin
      csum <= 8'h00;
    end else if (advance && (state != ST_CSUM)) begin
      csum <= csum ^ reply;
    end
  end

  // Payload byte index: steps on each acked data byte, back to 0 once the
  // last payload byte is acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (advance && (state == ST_DATA)) begin
      idx <= last_data ? '0 : idx + IDX_W'(1);
    end
  end

  reply_serializer_byte_sel #(
    .MAX_BYTES (MAX_BYTES),
    .LEN_W     (LEN_W),
    .IDX_W     (IDX_W)
  ) u_byte_sel (
    .state     (state),
    .id_q      (id_q),
    .len_q     (len_q),
    .data_q    (data_q),
    .idx       (idx),
    .csum      (csum),
    .reply_rdy (reply_rdy),
    .reply     (reply),
    .reply_end (reply_end)
  );

endmodule

// File: tb/tb_reply_serializer.sv
// Bench for reply_serializer: random and directed requests, with a
// frame-level reference model compared against the bus every cycle.
module tb_reply_serializer;
  import reply_serializer_pkg::*;

  localparam int MAX   = 8;
  localparam int LEN_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [7:0]         req_id = 8'h00;
  logic [LEN_W-1:0]   req_len = '0;
  logic [8*MAX-1:0]   req_data = '0;
  logic               reply_rdy;
  logic [7:0]         reply;
  logic               reply_ack = 1'b0;
  logic               reply_end;
  logic               len_err;
  logic [2:0]         fsm_state;

  reply_serializer #(.MAX_BYTES(MAX), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_len   (req_len),
    .req_data  (req_data),
    .reply_rdy (reply_rdy),
    .reply     (reply),
    .reply_ack (reply_ack),
    .reply_end (reply_end),
    .len_err   (len_err),
    .fsm_state (fsm_state)
  );

  // ---------------- counters / scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];       // bytes still expected for the current frame
  logic       exp_len_err = 1'b0;
  bit         armed = 1'b0;

  logic [7:0] rx_q[$];        // bytes seen acked in the frame in progress
  logic [7:0] last_frame[$];  // last completed frame as seen on the bus
  int frames_done = 0;
  int frame_cycles = 0;
  int last_frame_cycles = 0;
  int gap = 0;
  int last_gap = 0;
  int len_err_count = 0;
  int ack_mode = 0;           // 0: ack held high, 1: random stalls 0..4
  int stall_left = 0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process (negedge) ----------------
  always @(negedge clk) begin : monitor
    int         n;
    logic [7:0] x;
    logic [7:0] b;
    // check DUT against the model's view of this cycle
    if (armed) begin
      chk1("req_ready", req_ready, exp_q.size() == 0);
      chk1("reply_rdy", reply_rdy, exp_q.size() != 0);
      chk1("len_err", len_err, exp_len_err);
      if (exp_q.size() != 0) begin
        chk8("reply", reply, exp_q[0]);
        chk1("reply_end", reply_end, exp_q.size() == 1);
      end else begin
        chk1("reply_end_idle", reply_end, 1'b0);
      end
    end
    // record what the bus actually delivered
    if (reset) begin
      rx_q.delete();
      frame_cycles = 0;
      gap = 0;
    end else begin
      if (len_err === 1'b1) len_err_count++;
      if (reply_rdy === 1'b1) begin
        frame_cycles++;
        if (frame_cycles == 1) last_gap = gap;
      end else begin
        gap++;
      end
      if (reply_rdy === 1'b1 && reply_ack) begin
        rx_q.push_back(reply);
        if (reply_end === 1'b1) begin
          x = 8'h00;
          foreach (rx_q[i]) x ^= rx_q[i];
          chk8("frame_xor", x, 8'h00);
          last_frame = rx_q;
          last_frame_cycles = frame_cycles;
          frames_done++;
          frame_cycles = 0;
          gap = 0;
          rx_q.delete();
        end
      end
    end
    // predict the next cycle from the inputs the coming edge will see
    if (reset) begin
      exp_q.delete();
      exp_len_err = 1'b0;
      armed = 1'b1;
    end else if (exp_q.size() == 0) begin
      exp_len_err = 1'b0;
      if (req_valid) begin
        n = (int'(req_len) > MAX) ? MAX : int'(req_len);
        exp_len_err = (int'(req_len) > MAX);
        exp_q.push_back(req_id);
        exp_q.push_back(8'(n));
        x = req_id ^ 8'(n);
        for (int k = 0; k < n; k++) begin
          b = req_data[8*k +: 8];
          exp_q.push_back(b);
          x ^= b;
        end
        exp_q.push_back(x);
      end
    end else begin
      exp_len_err = 1'b0;
      if (reply_ack) void'(exp_q.pop_front());
    end
  end

  // ---------------- ack driver ----------------
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) begin
      reply_ack = 1'b1;
    end else if (stall_left > 0) begin
      reply_ack = 1'b0;
      stall_left--;
    end else begin
      reply_ack = 1'b1;
      stall_left = $urandom_range(0, 4);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [7:0] id, input logic [LEN_W-1:0] len,
                          input logic [8*MAX-1:0] data);
    int n;
    bit acc;
    req_valid = 1'b1;
    req_id    = id;
    req_len   = len;
    req_data  = data;
    n = 0;
    acc = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = (req_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    req_id    = 8'($urandom);
    req_len   = LEN_W'($urandom);
    req_data  = {$urandom, $urandom};
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL req_accept: request id %h not accepted within 300 cycles", id);
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (frames_done < target) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_wait: got %0d frames expected %0d", frames_done, target);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    do_reset(3);

    // basic frame with ack held high: 5 bytes in 5 consecutive cycles
    ack_mode = 0;
    base = frames_done;
    send_req(REPLY_ID_SAMPLE_CNT, 4'd2, 64'h1234_5678_9ABC_BEEF);
    wait_frames(base + 1);
    chki("t1_size", last_frame.size(), 5);
    if (last_frame.size() == 5) begin
      chk8("t1_b0", last_frame[0], 8'h06);
      chk8("t1_b1", last_frame[1], 8'h02);
      chk8("t1_b2", last_frame[2], 8'hEF);
      chk8("t1_b3", last_frame[3], 8'hBE);
      chk8("t1_csum", last_frame[4], 8'h55);
    end
    chki("t1_cycles", last_frame_cycles, 5);

    // zero-length frame
    base = frames_done;
    send_req(REPLY_ID_SEQOP, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_frames(base + 1);
    chki("t2_size", last_frame.size(), 3);
    if (last_frame.size() == 3) begin
      chk8("t2_b0", last_frame[0], 8'h01);
      chk8("t2_b1", last_frame[1], 8'h00);
      chk8("t2_csum", last_frame[2], 8'h01);
    end
    chki("t2_cycles", last_frame_cycles, 3);

    // full payload under random stalls
    ack_mode = 1;
    base = frames_done;
    send_req(REPLY_ID_PULSESEQ0, 4'd8, 64'h0102_0304_0506_0708);
    wait_frames(base + 1);
    chki("t3_size", last_frame.size(), 11);
    if (last_frame.size() == 11) begin
      chk8("t3_first_data", last_frame[2], 8'h08);
      chk8("t3_last_data", last_frame[9], 8'h01);
      chk8("t3_csum", last_frame[10], 8'h02);
    end

    // oversize length is clamped and flagged once
    len_err_count = 0;
    base = frames_done;
    send_req(REPLY_ID_PULSESEQ1, 4'd12, {$urandom, $urandom});
    wait_frames(base + 1);
    chki("t4_len_err_pulses", len_err_count, 1);
    chki("t4_size", last_frame.size(), 11);
    if (last_frame.size() == 11) chk8("t4_len_byte", last_frame[1], 8'h08);

    // back-to-back requests: one idle bus cycle between frames
    ack_mode = 0;
    base = frames_done;
    send_req(REPLY_ID_PULSESEQ2, 4'd1, 64'h0000_0000_0000_00A5);
    send_req(REPLY_ID_PULSESEQ3, 4'd1, 64'h0000_0000_0000_005A);
    wait_frames(base + 2);
    chki("t5_gap", last_gap, 1);
    if (last_frame.size() != 0) chk8("t5_second_id", last_frame[0], 8'h05);

    // reset during payload byte 3 aborts the frame
    send_req(REPLY_ID_STROBE_CTL, 4'd8, 64'h8877_6655_4433_2211);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk8("t6_byte3", reply, 8'h44);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("t6_rdy_after_reset", reply_rdy, 1'b0);
    chk1("t6_ready_after_reset", req_ready, 1'b1);
    @(posedge clk);
    #1;
    base = frames_done;
    send_req(REPLY_ID_SAMPLE_CNT, 4'd2, 64'h0000_0000_0000_BEEF);
    wait_frames(base + 1);
    if (last_frame.size() == 5) chk8("t6_csum", last_frame[4], 8'h55);
    else chki("t6_size", last_frame.size(), 5);

    // random traffic, some requests queued back-to-back
    base = frames_done;
    for (int i = 0; i < 40; i++) begin
      ack_mode = $urandom_range(0, 1);
      send_req(8'($urandom), LEN_W'($urandom_range(0, 12)), {$urandom, $urandom});
      if ($urandom_range(0, 1) == 0) wait_frames(base + i + 1);
    end
    wait_frames(base + 40);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
